tohost_mailbox: RTL and testbench
=================================

# tohost_mailbox

Device-side endpoint of the tohost/fromhost handshake used by the fuzzing harness. It snoops the core's memory-write path for stores to the tohost and fromhost doublewords and latches the tohost value into a register the testbench polls. It back-pressures further tohost stores until the host acknowledges. It also holds a host-written fromhost word that the core reads back. It sits in the test harness beside the memory model, feeding the `tohost` bus that the pass/timeout logic and coverage monitor consume.

## Interface
- TOHOST_ADDR, 64'h8000_1000, byte address of the tohost doubleword (8-byte aligned)
- FROMHOST_ADDR, 64'h8000_1040, byte address of the fromhost doubleword (8-byte aligned)
- ADDR_W, 64, address width
- clock  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  core store request
- wr_ready  out  1  store accepted when wr_valid && wr_ready at rising edge
- wr_addr  in  ADDR_W  store byte address
- wr_data  in  64  store data, doubleword-lane aligned
- wr_mask  in  8  byte enables
- rd_valid  in  1  core load request
- rd_addr  in  ADDR_W  load byte address
- rd_data  out  64  load data, valid one cycle after rd_valid
- host_ack  in  1  testbench consumed tohost; clears it
- fromhost_valid  in  1  host writes fromhost_data
- fromhost_data  in  64  host value
- tohost  out  64  latched tohost register
- tohost_pending  out  1  tohost nonzero and unacknowledged
- stall_cycles  out  32  cycles spent PENDING since last entry, saturating

## Operation
- Address hit: compare `addr[ADDR_W-1:3]` with `TOHOST_ADDR[ADDR_W-1:3]` / `FROMHOST_ADDR[ADDR_W-1:3]`; low 3 bits ignored.
- FSM states: IDLE, PENDING.
  - IDLE → PENDING on an accepted tohost store whose byte-merged result is nonzero.
  - A merged result of zero stays IDLE; the register still updates.
  - PENDING → IDLE on host_ack. tohost clears to 0 on the same edge.
- `wr_ready = !(state==PENDING && wr_valid && tohost hit)`. Non-hitting stores are always accepted and ignored; the memory model handles them.
- Byte merge: for each lane i with `wr_mask[i]` set, the new byte is `wr_data[8i+7:8i]`; other lanes keep the old value.
- Fromhost register:
  - Loaded with fromhost_data on fromhost_valid.
  - A core store to FROMHOST_ADDR byte-merges into it.
  - If both occur in the same cycle, the host wins.
- Reads: rd_data is registered.
  - tohost hit → tohost.
  - fromhost hit → fromhost.
  - Otherwise 0.
- stall_cycles: reset to 0 on PENDING entry; +1 per PENDING cycle; saturates at 32'hFFFF_FFFF; holds its value in IDLE.
- host_ack in IDLE: no effect.
- host_ack together with a tohost store in PENDING: ack wins, the store is stalled (wr_ready=0) and is accepted the next cycle.

## Timing
- Reset values: tohost=0, tohost_pending=0, rd_data=0, stall_cycles=0, fromhost=0, state=IDLE. wr_ready follows its combinational rule from reset.
- Reset asserted mid-PENDING clears all state immediately (asynchronously); stalled stores are dropped.
- An accepted store is visible on tohost/tohost_pending after the capturing edge, i.e. one cycle latency.
- host_ack to tohost=0/pending=0: one edge.
- rd_valid to rd_data: one cycle. A read in the same cycle as a write returns the pre-write value.
- wr_ready is a combinational function of state and inputs: there is no register on the path, and it does not depend on rd_*.

## Configuration
- `TOHOST_MAILBOX_TSTAMP_EN` defined:
  - adds a 64-bit free-running cycle counter (reset 0, wraps) and an output port `tohost_stamp` (out, 64);
  - tohost_stamp captures the counter value on every accepted tohost store that enters PENDING;
  - tohost_stamp clears on reset, not on ack.
- Undefined: no counter and no port.

## Structure
- `tohost_pkg`: state enum (IDLE, PENDING), default TOHOST/FROMHOST addresses, exit-code helpers (`code = tohost>>1`, pass when `tohost==1`).
- Sub-module `masked_reg64`: 64-bit register with byte-enable write and async active-low clear. Instantiated twice (tohost, fromhost).

## Test plan
- Store 64'h1 to 0x8000_1000 with mask 8'hFF → next cycle tohost=1, pending=1; host_ack → next cycle tohost=0, pending=0.
- Store 64'h0000_0000_0000_00AB with mask 8'h01 to 0x8000_1004 (unaligned low bits) → tohost=64'hAB, pending=1.
- Tohost store while PENDING → wr_ready=0 for 5 cycles, stall_cycles counts 1..5. Assert ack with the store still held → store accepted one cycle after ack, tohost=new value.
- fromhost_valid=1 with data 64'hDEAD together with a core store 64'h1 to 0x8000_1040 → fromhost=64'hDEAD. Read at 0x8000_1040 → rd_data=64'hDEAD one cycle later.
- Drop reset_n while PENDING with tohost=5 → outputs 0 immediately. After release, a store of 64'h3 is accepted at once.
- With TSTAMP_EN: tohost store at cycle 100 after reset → tohost_stamp=100. Same test without the macro compiles with no tohost_stamp port.

Source files
------------

// File: rtl/tohost_mailbox_pkg.sv
// Shared types, addresses and helpers for the tohost/fromhost mailbox.
package tohost_pkg;

  localparam int ADDR_W = 64;

  localparam logic [ADDR_W-1:0] TOHOST_ADDR   = 64'h8000_1000;
  localparam logic [ADDR_W-1:0] FROMHOST_ADDR = 64'h8000_1040;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Lanes with their enable set take the new byte; the rest keep the old one.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_q,
                                             input logic [63:0] data,
                                             input logic [7:0]  mask);
    logic [63:0] r;
    r = old_q;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

  // Doubleword match: the low three byte-offset bits never take part.
  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base);
    return addr[ADDR_W-1:3] == base[ADDR_W-1:3];
  endfunction

  function automatic logic [62:0] exit_code(input logic [63:0] tohost);
    return tohost[63:1];
  endfunction

  function automatic logic is_pass(input logic [63:0] tohost);
    return tohost == 64'd1;
  endfunction

endpackage

// File: rtl/tohost_mailbox_if.sv
// Core store/load path, host handshake and mailbox status bundled as one interface.
interface tohost_mailbox_if;

  logic                          wr_valid;
  logic                          wr_ready;
  logic [tohost_pkg::ADDR_W-1:0] wr_addr;
  logic [63:0]                   wr_data;
  logic [7:0]                    wr_mask;
  logic                          rd_valid;
  logic [tohost_pkg::ADDR_W-1:0] rd_addr;
  logic [63:0]                   rd_data;
  logic                          host_ack;
  logic                          fromhost_valid;
  logic [63:0]                   fromhost_data;
  logic [63:0]                   tohost;
  logic                          tohost_pending;
  logic [31:0]                   stall_cycles;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr,
           host_ack, fromhost_valid, fromhost_data,
    input  wr_ready, rd_data, tohost, tohost_pending, stall_cycles
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr,
           host_ack, fromhost_valid, fromhost_data,
    output wr_ready, rd_data, tohost, tohost_pending, stall_cycles
  );

endinterface

// File: rtl/tohost_mailbox_masked_reg64.sv
// 64-bit register with byte-enable write, synchronous clear and async active-low reset.
module masked_reg64
  import tohost_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        we,
  input  logic [7:0]  be,
  input  logic [63:0] d,
  output logic [63:0] q
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (clear) q <= '0;
    else if (we)    q <= byte_merge(q, d, be);
  end

endmodule

// File: rtl/tohost_mailbox.sv
// Tohost/fromhost mailbox endpoint snooping the core store path.
// Optional `TOHOST_MAILBOX_TSTAMP_EN adds a cycle counter and the tohost_stamp port.
module tohost_mailbox
  import tohost_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  tohost_mailbox_if.slave  bus
`ifdef TOHOST_MAILBOX_TSTAMP_EN
  ,
  output logic [63:0]      tohost_stamp
`endif
);

  state_t      state, state_nxt;
  logic [63:0] tohost_q, fromhost_q, tohost_merged;
  logic [63:0] fh_d;
  logic [7:0]  fh_be;
  logic        to_hit, fh_hit, to_acc, fh_we, ack_pend, enter_pend;
  logic [31:0] stall_q;
  logic [63:0] rd_q;

  assign to_hit = addr_hit(bus.wr_addr, TOHOST_ADDR);
  assign fh_hit = addr_hit(bus.wr_addr, FROMHOST_ADDR);

  // Only tohost stores are ever back-pressured, and only while unacknowledged.
  assign bus.wr_ready  = !(state == PENDING && bus.wr_valid && to_hit);
  assign to_acc        = bus.wr_valid && bus.wr_ready && to_hit;
  assign tohost_merged = byte_merge(tohost_q, bus.wr_data, bus.wr_mask);
  assign ack_pend      = (state == PENDING) && bus.host_ack;

  // Host load overrides a simultaneous core store by writing all lanes.
  assign fh_we = bus.fromhost_valid || (bus.wr_valid && fh_hit);
  assign fh_be = bus.fromhost_valid ? 8'hFF : bus.wr_mask;
  assign fh_d  = bus.fromhost_valid ? bus.fromhost_data : bus.wr_data;

  masked_reg64 u_tohost (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (ack_pend),
    .we      (to_acc),
    .be      (bus.wr_mask),
    .d       (bus.wr_data),
    .q       (tohost_q)
  );

  masked_reg64 u_fromhost (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (1'b0),
    .we      (fh_we),
    .be      (fh_be),
    .d       (fh_d),
    .q       (fromhost_q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    enter_pend = 1'b0;
    case (state)
      IDLE: begin
        if (to_acc && tohost_merged != '0) begin
          state_nxt  = PENDING;
          enter_pend = 1'b1;
        end
      end
      PENDING: if (bus.host_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (enter_pend) begin
      stall_q <= '0;
    end else if (state == PENDING && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  // Registered load path; a same-cycle store is not visible until next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else if (bus.rd_valid) begin
      if (addr_hit(bus.rd_addr, TOHOST_ADDR))        rd_q <= tohost_q;
      else if (addr_hit(bus.rd_addr, FROMHOST_ADDR)) rd_q <= fromhost_q;
      else                                           rd_q <= '0;
    end
  end

`ifdef TOHOST_MAILBOX_TSTAMP_EN
  logic [63:0] cycle_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q      <= '0;
      tohost_stamp <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
      if (enter_pend) tohost_stamp <= cycle_q;
    end
  end
`endif

  assign bus.tohost         = tohost_q;
  assign bus.tohost_pending = (state == PENDING);
  assign bus.stall_cycles   = stall_q;
  assign bus.rd_data        = rd_q;

endmodule

// File: tb/tb_tohost_mailbox.sv
// Self-checking bench for tohost_mailbox: directed test-plan steps, then random traffic
// checked against a behavioural mailbox model.
module tb_tohost_mailbox;
  import tohost_pkg::*;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  tohost_mailbox_if bus ();

`ifdef TOHOST_MAILBOX_TSTAMP_EN
  logic [63:0] tohost_stamp;
  tohost_mailbox dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .tohost_stamp (tohost_stamp)
  );
`else
  tohost_mailbox dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model of the mailbox contents
  logic [63:0] m_tohost, m_fromhost, m_rd;
  bit          m_pending;
  logic [31:0] m_stall;
  logic [63:0] m_cycles, m_stamp;

  function automatic logic [63:0] ref_merge(input logic [63:0] old_v,
                                            input logic [63:0] data,
                                            input logic [7:0]  mask);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  function automatic bit same_dword(input logic [63:0] a, input logic [63:0] b);
    return (a >> 3) == (b >> 3);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tohost   = '0;
    m_fromhost = '0;
    m_rd       = '0;
    m_pending  = 0;
    m_stall    = '0;
    m_cycles   = '0;
    m_stamp    = '0;
  endtask

  function automatic bit model_ready();
    return !(m_pending && bus.wr_valid && same_dword(bus.wr_addr, TOHOST_ADDR));
  endfunction

  // Apply one rising edge of the specified behaviour, using pre-edge state.
  task automatic model_edge();
    bit          to_hit, fh_hit, accepted;
    logic [63:0] merged;
    to_hit   = same_dword(bus.wr_addr, TOHOST_ADDR);
    fh_hit   = same_dword(bus.wr_addr, FROMHOST_ADDR);
    accepted = bus.wr_valid && model_ready();
    if (bus.rd_valid) begin
      if (same_dword(bus.rd_addr, TOHOST_ADDR))        m_rd = m_tohost;
      else if (same_dword(bus.rd_addr, FROMHOST_ADDR)) m_rd = m_fromhost;
      else                                             m_rd = '0;
    end
    if (bus.fromhost_valid)       m_fromhost = bus.fromhost_data;
    else if (bus.wr_valid && fh_hit) m_fromhost = ref_merge(m_fromhost, bus.wr_data, bus.wr_mask);
    if (m_pending) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (bus.host_ack) begin
        m_pending = 0;
        m_tohost  = '0;
      end
    end else if (accepted && to_hit) begin
      merged   = ref_merge(m_tohost, bus.wr_data, bus.wr_mask);
      m_tohost = merged;
      if (merged != 0) begin
        m_pending = 1;
        m_stall   = '0;
        m_stamp   = m_cycles;
      end
    end
    m_cycles = m_cycles + 1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid       = 1'b0;
    bus.wr_addr        = '0;
    bus.wr_data        = '0;
    bus.wr_mask        = '0;
    bus.rd_valid       = 1'b0;
    bus.rd_addr        = '0;
    bus.host_ack       = 1'b0;
    bus.fromhost_valid = 1'b0;
    bus.fromhost_data  = '0;
  endtask

  task automatic check_outputs(input string where);
    check({where, ".tohost"},  bus.tohost, m_tohost);
    check({where, ".pending"}, {63'd0, bus.tohost_pending}, {63'd0, m_pending});
    check({where, ".stall"},   {32'd0, bus.stall_cycles}, {32'd0, m_stall});
    check({where, ".rd_data"}, bus.rd_data, m_rd);
`ifdef TOHOST_MAILBOX_TSTAMP_EN
    check({where, ".stamp"}, tohost_stamp, m_stamp);
`endif
  endtask

  // Inputs are held from just after one edge to just after the next.
  task automatic step(input string where);
    @(negedge clock);
    check({where, ".wr_ready"}, {63'd0, bus.wr_ready}, {63'd0, model_ready()});
    @(posedge clock);
    model_edge();
    #1;
    check_outputs(where);
  endtask

  task automatic store(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] mask);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    bus.wr_mask  = mask;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    check_outputs("reset");
    check("reset.wr_ready", {63'd0, bus.wr_ready}, 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    model_edge();
    #1;

    // tohost=1 then ack
    store(TOHOST_ADDR, 64'h1, 8'hFF);
    step("t1_store");
    check("t1.tohost_is_1", bus.tohost, 64'h1);
    idle_inputs();
    bus.host_ack = 1'b1;
    step("t1_ack");
    check("t1.cleared", bus.tohost, 64'h0);
    idle_inputs();

    // single-lane store at unaligned address
    store(TOHOST_ADDR + 64'h4, 64'hAB, 8'h01);
    step("t2_store");
    check("t2.tohost_ab", bus.tohost, 64'hAB);

    // stalled store, ack while the store is held
    store(TOHOST_ADDR, 64'h77, 8'hFF);
    for (int k = 1; k <= 5; k++) begin
      step("t3_stall");
      check("t3.stall_count", {32'd0, bus.stall_cycles}, k);
    end
    bus.host_ack = 1'b1;
    step("t3_ack");
    bus.host_ack = 1'b0;
    step("t3_accept");
    check("t3.new_value", bus.tohost, 64'h77);
    idle_inputs();
    bus.host_ack = 1'b1;
    step("t3_ack2");
    idle_inputs();

    // host write beats a simultaneous core store, then read back
    store(FROMHOST_ADDR, 64'h1, 8'hFF);
    bus.fromhost_valid = 1'b1;
    bus.fromhost_data  = 64'hDEAD;
    step("t4_write");
    idle_inputs();
    bus.rd_valid = 1'b1;
    bus.rd_addr  = FROMHOST_ADDR;
    step("t4_read");
    check("t4.rd_dead", bus.rd_data, 64'hDEAD);
    idle_inputs();

    // reset while pending with a stalled store held
    store(TOHOST_ADDR, 64'h5, 8'hFF);
    step("t5_store");
    store(TOHOST_ADDR, 64'h9, 8'hFF);
    step("t5_stalled");
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t5_in_reset");
    #2;
    reset_n = 1'b1;
    store(TOHOST_ADDR, 64'h3, 8'hFF);
    step("t5_after");
    check("t5.tohost_3", bus.tohost, 64'h3);
    idle_inputs();
    bus.host_ack = 1'b1;
    step("t5_ack");
    idle_inputs();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [63:0] a, rd_a;
      idle_inputs();
      case ($urandom_range(0, 3))
        0:       a = TOHOST_ADDR | 64'($urandom_range(0, 7));
        1:       a = FROMHOST_ADDR | 64'($urandom_range(0, 7));
        2:       a = TOHOST_ADDR + 64'h8;
        default: a = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 2) != 0) begin
        store(a, ($urandom_range(0, 4) == 0) ? 64'h0 : {$urandom, $urandom},
              8'($urandom_range(0, 255)));
      end
      bus.host_ack       = ($urandom_range(0, 3) == 0);
      bus.fromhost_valid = ($urandom_range(0, 7) == 0);
      bus.fromhost_data  = {$urandom, $urandom};
      bus.rd_valid       = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0:       rd_a = TOHOST_ADDR | 64'($urandom_range(0, 7));
        1:       rd_a = FROMHOST_ADDR | 64'($urandom_range(0, 7));
        default: rd_a = {$urandom, $urandom};
      endcase
      bus.rd_addr = rd_a;
      step("rand");
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
